port_scan_ctrl: RTL and testbench
=================================

PORT_SCAN_CTRL -- requirements
Module: port_scan_ctrl

Interface
REQ-001 Parameter DATA_W, 8, data path width in bits.
REQ-002 Parameter PKT_LEN, 4, maximum beats per packet (range 1..15).
REQ-003 Parameter TIMEOUT, 15, idle cycles allowed in GRANT before abort (range 1..15).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin one scan sweep of ports 0..3; sampled in IDLE only.
REQ-007 req  input  4  per-port transfer request, bit i = port i.
REQ-008 port_num  input  2  current port index from the downstream port-number counter.
REQ-009 cnt  output  1  one-cycle increment pulse to the port-number counter.
REQ-010 grant  output  4  one-hot grant to port port_num.
REQ-011 valid_in  input  1  beat valid from granted port.
REQ-012 last_in  input  1  final beat of packet, qualified by valid_in.
REQ-013 data_in  input  DATA_W  beat data from granted port.
REQ-014 valid_out  output  1  registered forward of accepted beat.
REQ-015 data_out  output  DATA_W  registered forward of accepted data.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at sweep completion.
REQ-018 err  output  1  sticky timeout flag; cleared only by rst or start accepted in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, CHECK, GRANT, XFER, ADVANCE, SETTLE, DONE.
REQ-020 IDLE: start=1 -> CHECK; visit counter cleared to 0; err cleared.
REQ-021 CHECK: req[port_num]=1 -> GRANT; else -> ADVANCE.
REQ-022 GRANT: grant[port_num]=1; valid_in=1 -> XFER with that beat accepted; else timeout counter increments.
REQ-023 GRANT: timeout counter reaching TIMEOUT with no valid_in -> ADVANCE, err set to 1.
REQ-024 XFER: grant held; each valid_in beat accepted; beat counter increments per accepted beat.
REQ-025 XFER exit -> ADVANCE when accepted beat has last_in=1 or beat count reaches PKT_LEN, whichever first.
REQ-026 Accepted beat appears on valid_out/data_out exactly 1 cycle after acceptance; valid_out=0 otherwise.
REQ-027 Beats with valid_in=1 outside GRANT/XFER SHALL be ignored (no valid_out).
REQ-028 ADVANCE: cnt=1 for exactly this one cycle; grant=0; visit counter increments.
REQ-029 SETTLE: one cycle for counter update; visit counter = 4 -> DONE, else -> CHECK.
REQ-030 DONE: done=1 for one cycle -> IDLE.
REQ-031 Timeout and beat counters SHALL clear on every entry to GRANT.
REQ-032 Visit counter 3 bits; no wrap before 4; port_num wrap 3->0 is the downstream counter's job.
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 req changes during GRANT/XFER SHALL NOT affect current grant.
REQ-035 grant SHALL be zero whenever state is not GRANT or XFER.

Reset
REQ-036 rst=1 SHALL force IDLE immediately, mid-operation included.
REQ-037 Reset values: cnt=0, grant=0, valid_out=0, data_out=0, busy=0, done=0, err=0, all internal counters 0.

Structure
REQ-038 Shared package SHALL hold the state enumeration and default DATA_W/PKT_LEN/TIMEOUT constants.
REQ-039 One sub-module port_xfer_cnt SHALL hold beat and timeout counters with clear/enable inputs; FSM stays in top.

Verification
REQ-040 start, req=4'b1111, each port sends 2 beats with last_in on beat 2 -> 8 valid_out beats, 4 cnt pulses, done once, err=0.
REQ-041 start, req=4'b0000 -> no grant ever, 4 cnt pulses spaced 3 cycles apart, done pulse, err=0.
REQ-042 req[2]=1, port 2 never asserts valid_in -> grant[2] held 15 cycles, then cnt pulse, err=1 until next start.
REQ-043 req[0]=1, port 0 streams 6 beats without last_in, PKT_LEN=4 -> exactly 4 valid_out beats, then cnt pulse.
REQ-044 rst asserted during XFER on port 1 -> grant=0, valid_out=0, busy=0 same cycle; next start restarts sweep.
REQ-045 start pulsed while busy=1 -> ignored; single done pulse at end of original sweep.

Source files
------------

// File: rtl/port_scan_ctrl_pkg.sv
// Shared definitions for the port scan controller: default sizing, FSM
// state encoding and small helpers used by the top and its counter block.
package port_scan_ctrl_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int PKT_LEN_DEF = 4;
    localparam int TIMEOUT_DEF = 15;

    localparam int CNT_W   = 4;
    localparam int VISIT_W = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_GRANT   = 3'd2;
    localparam logic [2:0] S_XFER    = 3'd3;
    localparam logic [2:0] S_ADVANCE = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    function automatic logic [3:0] port_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/port_scan_ctrl_if.sv
// Port-side bundle of the scan controller: sweep control, per-port grant
// handshake, beat input and registered beat output.
interface port_scan_ctrl_if #(
    parameter int DATA_W = port_scan_ctrl_pkg::DATA_W_DEF
);
    logic              start;
    logic [3:0]        req;
    logic [1:0]        port_num;
    logic              cnt;
    logic [3:0]        grant;
    logic              valid_in;
    logic              last_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, req, port_num, valid_in, last_in, data_in,
        output cnt, grant, valid_out, data_out, busy, done, err
    );

    modport master (
        output start, req, port_num, valid_in, last_in, data_in,
        input  cnt, grant, valid_out, data_out, busy, done, err
    );

endinterface

// File: rtl/port_scan_ctrl_xfer_cnt.sv
// Beat and timeout counters for the currently granted port; both clear
// together when a new grant begins.
module port_xfer_cnt
    import port_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             beat_en_i,
    input  logic             tmo_en_i,
    output logic [CNT_W-1:0] beat_o,
    output logic [CNT_W-1:0] tmo_o
);

    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    always_comb begin
        beat_d = beat_q;
        tmo_d  = tmo_q;
        if (clr_i) begin
            beat_d = '0;
            tmo_d  = '0;
        end else begin
            if (beat_en_i) beat_d = beat_q + 1'b1;
            if (tmo_en_i)  tmo_d  = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            tmo_q  <= '0;
        end else begin
            beat_q <= beat_d;
            tmo_q  <= tmo_d;
        end
    end

    assign beat_o = beat_q;
    assign tmo_o  = tmo_q;

endmodule

// File: rtl/port_scan_ctrl.sv
// Sweeps ports 0..3 once per start, granting each requesting port for one
// packet and forwarding its beats one cycle later; flags grant timeouts.
module port_scan_ctrl
    import port_scan_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    port_scan_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]         state_q, state_d;
    logic [VISIT_W-1:0] visit_q, visit_d;
    logic               err_q, err_d;
    logic               valid_out_q;
    logic [DATA_W-1:0]  data_out_q;

    logic             in_grant;
    logic             accept;
    logic             cnt_clr, beat_en, tmo_en;
    logic [CNT_W-1:0] beat_cnt, tmo_cnt;

    port_xfer_cnt u_xfer_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .beat_en_i (beat_en),
        .tmo_en_i  (tmo_en),
        .beat_o    (beat_cnt),
        .tmo_o     (tmo_cnt)
    );

    assign in_grant = (state_q == S_GRANT) || (state_q == S_XFER);
    assign accept   = in_grant && bus.valid_in;

    always_comb begin
        state_d = state_q;
        visit_d = visit_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        beat_en = 1'b0;
        tmo_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CHECK;
                    visit_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_CHECK: begin
                if (bus.req[bus.port_num]) begin
                    state_d = S_GRANT;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = S_ADVANCE;
                end
            end
            S_GRANT: begin
                if (bus.valid_in) begin
                    beat_en = 1'b1;
                    // A single-beat packet (or PKT_LEN of 1) finishes straight from GRANT.
                    state_d = (bus.last_in || beat_cnt == PKT_LAST) ? S_ADVANCE : S_XFER;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = S_ADVANCE;
                    err_d   = 1'b1;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            S_XFER: begin
                if (bus.valid_in) begin
                    beat_en = 1'b1;
                    if (bus.last_in || beat_cnt == PKT_LAST) state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                visit_d = visit_q + 3'd1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = (visit_q == 3'd4) ? S_DONE : S_CHECK;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            visit_q     <= '0;
            err_q       <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            visit_q     <= visit_d;
            err_q       <= err_d;
            valid_out_q <= accept;
            if (accept) data_out_q <= bus.data_in;
        end
    end

    assign bus.cnt       = (state_q == S_ADVANCE);
    assign bus.grant     = in_grant ? port_onehot(bus.port_num) : 4'b0000;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_port_scan_ctrl.sv
// Randomized sweep bench for port_scan_ctrl: scripted port behaviour per sweep,
// expected beats and flags derived from the packet rules at transaction level.
module tb_port_scan_ctrl;

    localparam int DW = 8;
    localparam int PL = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    port_scan_ctrl_if #(.DATA_W(DW)) bus ();

    port_scan_ctrl #(.DATA_W(DW), .PKT_LEN(PL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Downstream port-number counter
    always @(posedge clk or posedge rst) begin
        if (rst) bus.port_num <= 2'd0;
        else if (bus.cnt) bus.port_num <= bus.port_num + 2'd1;
    end

    int checks = 0;
    int errors = 0;

    // Port script: kind 0 = packet ending with last_in, 1 = stream without last_in, 2 = silent
    int         kind [4];
    int         nb   [4];
    int         gap0 [4];
    int         idx  [4];
    int         gcyc [4];
    logic [7:0] bdata [4][8];
    logic [3:0] sweep_req;
    logic [7:0] expq [$];
    int         cnt_at [$];
    logic       exp_err;
    logic       prev_g;
    int         gap, ncnt, ndone, cyc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        int p;
        @(negedge clk);
        cyc++;
        if (bus.valid_out) begin
            if (expq.size() == 0) check_val("extra_beat", 1, 0);
            else check_val("beat_data", bus.data_out, expq.pop_front());
        end
        if (bus.cnt) begin
            ncnt++;
            cnt_at.push_back(cyc);
        end
        if (bus.done) ndone++;
        if (bus.grant != 4'b0000) begin
            check_val("grant_port", bus.grant, 32'd1 << bus.port_num);
            gcyc[bus.port_num]++;
        end
        if (bus.grant != 4'b0000) begin
            p = int'(bus.port_num);
            if (!prev_g) gap = gap0[p];
            prev_g  = 1'b1;
            bus.req = 4'($urandom);
            if (kind[p] == 2 || gap > 0 || idx[p] >= nb[p]) begin
                bus.valid_in = 1'b0;
                bus.last_in  = 1'b0;
                if (gap > 0) gap--;
            end else begin
                bus.valid_in = 1'b1;
                bus.data_in  = bdata[p][idx[p]];
                bus.last_in  = (kind[p] == 0) && (idx[p] == nb[p] - 1);
                idx[p]++;
                gap = $urandom_range(0, 2);
            end
        end else begin
            prev_g       = 1'b0;
            bus.req      = sweep_req;
            bus.valid_in = 1'($urandom);
            bus.data_in  = 8'($urandom);
            bus.last_in  = 1'($urandom);
        end
    endtask

    task automatic set_port(input int p, input int k, input int n, input int g);
        kind[p] = k;
        nb[p]   = n;
        gap0[p] = g;
        for (int j = 0; j < 8; j++) bdata[p][j] = 8'($urandom);
    endtask

    task automatic rand_scripts();
        int r;
        for (int p = 0; p < 4; p++) begin
            r = $urandom_range(0, 5);
            if (r <= 2)      set_port(p, 0, $urandom_range(1, 6), $urandom_range(0, 3));
            else if (r <= 4) set_port(p, 1, $urandom_range(PL + 1, PL + 2), $urandom_range(0, 3));
            else             set_port(p, 2, 0, 0);
        end
    endtask

    task automatic prep(input logic [3:0] r);
        int acc;
        sweep_req = r;
        expq.delete();
        cnt_at.delete();
        exp_err = 1'b0;
        ncnt = 0; ndone = 0; gap = 0; prev_g = 1'b0;
        for (int p = 0; p < 4; p++) begin
            idx[p]  = 0;
            gcyc[p] = 0;
            if (r[p]) begin
                if (kind[p] == 2) exp_err = 1'b1;
                else begin
                    acc = (nb[p] < PL) ? nb[p] : PL;
                    for (int j = 0; j < acc; j++) expq.push_back(bdata[p][j]);
                end
            end
        end
    endtask

    task automatic run_sweep(input logic [3:0] r, input bit dup_start);
        int post;
        prep(r);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        post = 0;
        for (int n = 0; n < 400; n++) begin
            step();
            if (dup_start && n == 8) begin
                check_val("busy_at_dup_start", bus.busy, 1);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (ndone > 0) post++;
            if (post >= 4) break;
        end
        check_val("done_pulses", ndone, 1);
        check_val("cnt_pulses", ncnt, 4);
        check_val("err_flag", bus.err, exp_err);
        check_val("beats_missing", expq.size(), 0);
        check_val("busy_after_done", bus.busy, 0);
        check_val("port_num_wrap", bus.port_num, 0);
        for (int p = 0; p < 4; p++) begin
            if (!r[p]) check_val("grant_no_req", gcyc[p], 0);
            else if (kind[p] == 2) check_val("grant_timeout_len", gcyc[p], TO);
        end
        if (r == 4'b0000 && cnt_at.size() >= 4)
            for (int i = 0; i < 3; i++) check_val("cnt_spacing", cnt_at[i+1] - cnt_at[i], 3);
    endtask

    initial begin
        bus.start = 1'b0; bus.req = 4'b0000; bus.valid_in = 1'b0;
        bus.last_in = 1'b0; bus.data_in = '0;
        sweep_req = 4'b0000; cyc = 0; prev_g = 1'b0; gap = 0;
        for (int p = 0; p < 4; p++) set_port(p, 0, 1, 0);
        repeat (2) @(negedge clk);
        check_val("rst_cnt", bus.cnt, 0);
        check_val("rst_grant", bus.grant, 0);
        check_val("rst_valid_out", bus.valid_out, 0);
        check_val("rst_data_out", bus.data_out, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_err", bus.err, 0);
        rst = 1'b0;

        // All ports request, two beats each with last_in on the second
        for (int p = 0; p < 4; p++) set_port(p, 0, 2, 0);
        run_sweep(4'b1111, 1'b0);

        // No requests at all
        run_sweep(4'b0000, 1'b0);

        // Port 2 requests but never sends; err must stick until next start
        set_port(2, 2, 0, 0);
        run_sweep(4'b0100, 1'b0);
        repeat (5) step();
        check_val("err_sticky", bus.err, 1);
        run_sweep(4'b0000, 1'b0);

        // Port 0 streams 6 beats without last_in; truncated at PKT_LEN
        set_port(0, 1, 6, 0);
        run_sweep(4'b0001, 1'b0);

        // start pulsed mid-sweep must be ignored
        rand_scripts();
        run_sweep(4'($urandom), 1'b1);

        // Reset during XFER on port 1
        set_port(1, 1, 6, 0);
        prep(4'b0010);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (idx[1] >= 2 && bus.grant != 4'b0000) break;
            step();
        end
        check_val("xfer_reached", (idx[1] >= 2) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        check_val("rst_mid_grant", bus.grant, 0);
        check_val("rst_mid_valid_out", bus.valid_out, 0);
        check_val("rst_mid_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        rand_scripts();
        run_sweep(4'($urandom), 1'b0);

        for (int s = 0; s < 20; s++) begin
            rand_scripts();
            run_sweep(4'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
